mpeg_input_stream_bitreader: RTL and testbench
==============================================

// Module: mpeg_input_stream_bitreader
// PURPOSE
//  Read side of the 8 KB MPEG input stream FIFO (byte-written, 2048x32 read RAM).
//  Fetches 32-bit words from the RAM, reorders bytes into stream order and presents
//  a left-aligned bit window to the MPEG parser. The parser consumes 1..32 bits per cycle.
//  Reports its read pointer back to the byte writer for full/free-space computation.
// PARAMETERS
//  WORD_AW  11  RAM word address width (2^11 words x 4 B = 8 KB)
// PORTS
//  clk            in   1         single clock; all logic on rising edge
//  reset_n        in   1         synchronous reset, active low
//  wptr           in   WORD_AW+3 writer byte pointer incl. wrap bit (bytes written, mod 2^(WORD_AW+3))
//  flush          in   1         discard all buffered data; pointers return to 0 (writer flushes same cycle)
//  raddr          out  WORD_AW   RAM read address
//  q              in   32        RAM read data, valid 1 cycle after raddr
//  rptr           out  WORD_AW+3 bytes released to writer = rd_word_ptr*4, incl. wrap bit
//  window         out  32        next stream bits, MSB = oldest bit; bits beyond bit_count are 0
//  bit_count      out  7         valid bits buffered, 0..64
//  consume_valid  in   1         parser request to drop consume_len bits
//  consume_len    in   6         bits to drop, 1..32; 0 = no-op
//  consume_ready  out  1         combinational: bit_count >= consume_len and !byte_align
//  byte_align     in   1         drop (bit_count mod 8) bits to reach a byte boundary
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): raddr=0, rptr=0, bit_count=0, window=0, rd_word_ptr=0,
//    in-flight flag cleared. flush has identical effect; a RAM word in flight is dropped.
//  - rd_word_ptr: WORD_AW+1 bits (wrap bit); raddr = rd_word_ptr[WORD_AW-1:0].
//  - Word available when wptr[WORD_AW+2:2] != rd_word_ptr (only complete words; trailing
//    partial word waits for writer to fill it or pad).
//  - Fetch: if available, no read in flight and bit_count_after_consume <= 32: drive raddr,
//    set in-flight, rd_word_ptr++ (wraps 2047->0, wrap bit toggles). At most one read in flight.
//  - Next cycle: word = {q[7:0],q[15:8],q[23:16],q[31:24]} (byte lane 0 is first in stream);
//    appended directly below the last valid bit of 64-bit buffer buf; bit_count += 32.
//  - window = buf[63:32]. Consume handshake: consume_valid & consume_ready -> buf <<= len,
//    bit_count -= len in the same edge. Request with !consume_ready has no effect; parser holds it.
//  - Simultaneous consume + append: shift first, then append at 64-(bit_count-len);
//    bit_count_next = bit_count - len + 32 (never > 64, guaranteed by fetch rule).
//  - byte_align has priority: consume_ready=0 that cycle; drops bit_count[2:0] bits
//    (no-op if already aligned). Counted from stream start; reset/flush realign to 0.
//  - rptr updates on fetch issue (space freed once the RAM read is issued; RAM is read-before-write
//    safe since writer cannot reach a word until rptr passes it). Writer full: wptr - rptr == 8192.
//  - Empty FIFO: no fetch, window drains, consume_ready drops once bit_count < consume_len.
//  - Full FIFO (wptr - rptr = 8192): word available (pointers differ in wrap bit only); read normally.
//  - flush concurrent with consume/append: flush wins, all discarded.
//  - Throughput: sustained 32 bits/cycle impossible (one fetch per 2 cycles max when draining 32/cycle
//    is acceptable); parser rate <= 16 bits/cycle average never starves while data is present.
// STRUCTURE
//  - Package mpeg_input_stream_pkg: FIFO_BYTES=8192, WORD_AW=11, typedef word_ptr_t
//    (logic [WORD_AW:0]), typedef byte_ptr_t (logic [WORD_AW+2:0]); shared with the byte writer.
//  - Single module; RAM instance lives in the parent. Barrel shift/append coded inline
//    (combinational next-buf function), registers: buf, bit_count, rd_word_ptr, inflight.
// TESTING
//  1 Reset: write bytes 12 34 56 78 (wptr=4) -> raddr=0 fetched, window=32'h12345678,
//    bit_count=32 within 3 cycles of wptr update; rptr=4.
//  2 Consume: 8 bytes 12..89 (12 34 56 78 9A BC DE F0 then), consume 4 -> window=32'h23456789;
//    consume 12 -> window=32'h56789ABC; consume_len=33-bit request impossible, len 32 with
//    bit_count=20 -> consume_ready=0, state unchanged.
//  3 Simultaneous: bit_count=32 + append landing while consuming 8 -> bit_count=56, window
//    continuous (no bit lost/duplicated) over 1000 random consume lengths vs byte-stream model.
//  4 Wrap/full: stream 3 x 8192 bytes, writer stalls on wptr-rptr==8192 -> output bit-exact,
//    raddr wraps 2047->0, rptr wrap bit toggles each 8 KB.
//  5 byte_align: consume 3 bits then byte_align -> bit_count drops by 5, window starts at byte 1.
//  6 flush/reset mid-fetch: assert flush cycle after raddr issued -> bit_count=0, rptr=0,
//    late q ignored; reset_n=0 mid-stream -> all outputs at reset values next edge.

Source files
------------

// File: rtl/mpeg_input_stream_bitreader_pkg.sv
// Shared types for the MPEG input stream FIFO.
// Used by both the byte writer and the bit reader.
package mpeg_input_stream_pkg;

  localparam int FIFO_BYTES = 8192;
  localparam int WORD_AW    = 11;

  typedef logic [WORD_AW:0]   word_ptr_t;
  typedef logic [WORD_AW+2:0] byte_ptr_t;
  typedef logic [6:0]         bcnt_t;

  // Byte lane 0 is the oldest byte in the stream.
  function automatic logic [31:0] stream_order(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mpeg_input_stream_bitreader_if.sv
// Bit reader bus: writer pointers, RAM read port
// and parser bit window handshake.
interface mpeg_input_stream_bitreader_if;
  import mpeg_input_stream_pkg::*;

  byte_ptr_t          wptr;
  logic               flush;
  logic [WORD_AW-1:0] raddr;
  logic [31:0]        q;
  byte_ptr_t          rptr;
  logic [31:0]        window;
  bcnt_t              bit_count;
  logic               consume_valid;
  logic [5:0]         consume_len;
  logic               consume_ready;
  logic               byte_align;

  modport slave (
    input  wptr,
    input  flush,
    input  q,
    input  consume_valid,
    input  consume_len,
    input  byte_align,
    output raddr,
    output rptr,
    output window,
    output bit_count,
    output consume_ready
  );

  modport master (
    output wptr,
    output flush,
    output q,
    output consume_valid,
    output consume_len,
    output byte_align,
    input  raddr,
    input  rptr,
    input  window,
    input  bit_count,
    input  consume_ready
  );

endinterface

// File: rtl/mpeg_input_stream_bitreader.sv
// Read side of the MPEG input FIFO: fetches RAM
// words and serves a left-aligned bit window.
module mpeg_input_stream_bitreader
  import mpeg_input_stream_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  mpeg_input_stream_bitreader_if.slave  bus
);

  logic [63:0] sbuf_q, sbuf_d;
  bcnt_t       cnt_q, cnt_d;
  word_ptr_t   wp_q, wp_d;
  logic        infl_q, infl_d;

  logic [5:0]  sh;
  bcnt_t       cnt_aft;
  logic        ready;
  logic        avail;
  logic        fetch;
  logic [31:0] word;
  logic        unused_wptr_lsb;

  // Shift out consumed bits, then land a new word
  // right below the last surviving valid bit.
  function automatic logic [63:0] next_buf(
    input logic [63:0] b,
    input logic [5:0]  s,
    input bcnt_t       at,
    input logic        app,
    input logic [31:0] w
  );
    logic [63:0] r;
    r = b << s;
    if (app)
      r = r | ({w, 32'h0} >> at);
    return r;
  endfunction

  assign unused_wptr_lsb = ^bus.wptr[1:0];

  assign ready = (cnt_q >= {1'b0, bus.consume_len})
               && !bus.byte_align;

  always_comb begin
    sh = '0;
    unique case (1'b1)
      bus.byte_align:
        sh = {3'b000, cnt_q[2:0]};
      bus.consume_valid && ready:
        sh = bus.consume_len;
      default:
        sh = '0;
    endcase
  end

  assign cnt_aft = cnt_q - {1'b0, sh};
  assign avail   = bus.wptr[WORD_AW+2:2] != wp_q;
  assign fetch   = avail && !infl_q
                 && (cnt_aft <= 7'd32);
  assign word    = stream_order(bus.q);

  always_comb begin
    sbuf_d = next_buf(sbuf_q, sh, cnt_aft,
                      infl_q, word);
    cnt_d  = cnt_aft
           + (infl_q ? 7'd32 : 7'd0);
    wp_d   = wp_q + word_ptr_t'(fetch);
    infl_d = fetch;
  end

  // Flush drops any word still in flight.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      sbuf_q <= '0;
      cnt_q  <= '0;
      wp_q   <= '0;
      infl_q <= 1'b0;
    end else begin
      sbuf_q <= sbuf_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      infl_q <= infl_d;
    end
  end

  assign bus.raddr         = wp_q[WORD_AW-1:0];
  assign bus.rptr          = {wp_q, 2'b00};
  assign bus.window        = sbuf_q[63:32];
  assign bus.bit_count     = cnt_q;
  assign bus.consume_ready = ready;

endmodule

// File: tb/tb_mpeg_input_stream_bitreader.sv
// Bench for the MPEG input stream bit reader:
// byte-stream reference model plus directed cases.
module tb_mpeg_input_stream_bitreader;
  import mpeg_input_stream_pkg::*;

  localparam int TOT = 3 * FIFO_BYTES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpeg_input_stream_bitreader_if bus ();

  mpeg_input_stream_bitreader dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  logic [31:0] mem [2048];
  always @(posedge clk) bus.q <= mem[bus.raddr];

  int nchk  = 0;
  int npass = 0;
  int m_cons, m_app, m_fetch, wtot, full_seen;
  bit m_infl;
  logic [7:0] sbytes[$];
  logic [7:0] src[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] exp_win(int bc);
    logic [31:0] w;
    int p;
    w = '0;
    for (int i = 0; i < 32; i++)
      if (i < bc) begin
        p = m_cons + i;
        w[31-i] = sbytes[p/8][7-(p%8)];
      end
    return w;
  endfunction

  task automatic tick(input bit cv, input int len,
                      input bit ba, input bit fl,
                      input bit rs, input bit wen);
    int bc, sh, aft;
    bit rdy, fetch;
    byte_ptr_t d, a;
    logic [7:0] b;
    logic [31:0] wd;
    @(negedge clk);
    rst_n             = ~rs;
    bus.flush         = fl;
    bus.consume_valid = cv;
    bus.consume_len   = 6'(len);
    bus.byte_align    = ba;
    d = bus.wptr - bus.rptr;
    if (d == byte_ptr_t'(FIFO_BYTES)) full_seen++;
    if (rs || fl) bus.wptr = '0;
    else if (wen && src.size() > 0
             && d < byte_ptr_t'(FIFO_BYTES)) begin
      b  = src.pop_front();
      a  = bus.wptr;
      wd = mem[a[12:2]];
      wd[8*a[1:0] +: 8] = b;
      mem[a[12:2]] = wd;
      bus.wptr = bus.wptr + 1'b1;
      sbytes.push_back(b);
      wtot++;
    end
    #1;
    bc  = m_app * 32 - m_cons;
    rdy = !ba && (bc >= len);
    check("bit_count", bus.bit_count, bc);
    check("window", bus.window, exp_win(bc));
    check("consume_ready", bus.consume_ready, rdy);
    check("rptr", bus.rptr, (m_fetch * 4) % 16384);
    check("raddr", bus.raddr, m_fetch % 2048);
    if (rs || fl) begin
      m_cons = 0; m_app = 0; m_fetch = 0;
      m_infl = 0; wtot = 0;
      sbytes.delete();
      src.delete();
    end else begin
      sh = ba ? (8 - m_cons % 8) % 8
              : ((cv && rdy) ? len : 0);
      aft   = bc - sh;
      fetch = (wtot / 4 > m_fetch) && !m_infl
              && aft <= 32;
      m_cons += sh;
      if (m_infl) m_app++;
      m_infl = fetch;
      if (fetch) m_fetch++;
    end
  endtask

  task automatic push4(input logic [31:0] v);
    for (int i = 3; i >= 0; i--)
      src.push_back(v[8*i +: 8]);
  endtask

  initial begin
    bus.wptr          = '0;
    bus.flush         = 1'b0;
    bus.consume_valid = 1'b0;
    bus.consume_len   = '0;
    bus.byte_align    = 1'b0;
    m_cons = 0; m_app = 0; m_fetch = 0;
    m_infl = 0; wtot = 0; full_seen = 0;
    repeat (2) @(posedge clk);
    tick(0, 0, 0, 0, 1, 0);

    // first word lands as 12345678
    push4(32'h12345678);
    repeat (4) tick(0, 0, 0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    check("t1_window", bus.window, 32'h12345678);
    check("t1_count", bus.bit_count, 32);
    check("t1_rptr", bus.rptr, 4);

    push4(32'h9abcdef0);
    repeat (4) tick(0, 0, 0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    check("t2_count64", bus.bit_count, 64);
    tick(1, 4, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t2_win4", bus.window, 32'h23456789);
    tick(1, 12, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t2_win16", bus.window, 32'h56789abc);
    tick(1, 28, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t2_count20", bus.bit_count, 20);
    tick(1, 32, 0, 0, 0, 0);
    check("t2_stall_rdy", bus.consume_ready, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t2_stall_cnt", bus.bit_count, 20);

    // reset mid-stream, then byte_align
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_count", bus.bit_count, 0);
    check("rst_rptr", bus.rptr, 0);
    check("rst_window", bus.window, 0);
    push4(32'h12345678);
    push4(32'h9abcdef0);
    repeat (8) tick(0, 0, 0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    tick(1, 3, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    check("t5_c3", bus.bit_count, 61);
    tick(0, 0, 0, 0, 0, 0);
    check("t5_count", bus.bit_count, 56);
    check("t5_window", bus.window, 32'h3456789a);

    // flush with a read in flight
    tick(0, 0, 0, 0, 1, 0);
    push4(32'hcafef00d);
    repeat (4) tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t6_count", bus.bit_count, 0);
    check("t6_rptr", bus.rptr, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t6_late_q", bus.bit_count, 0);

    // random stream: slow parser fills FIFO, then drains
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TOT; i++)
      src.push_back(8'($urandom));
    for (int c = 0; c < 60000; c++) begin
      int len;
      bit cv, ba;
      cv  = (c < 14000) ? ($urandom_range(15) == 0)
                        : ($urandom_range(3) != 0);
      len = ($urandom_range(31) == 0)
            ? 0 : int'($urandom_range(32, 1));
      ba  = ($urandom_range(63) == 0);
      tick(cv, len, ba, 0, 0,
           $urandom_range(7) != 0);
    end
    tick(0, 0, 0, 0, 0, 0);
    check("final_rptr", bus.rptr, 14'h2000);
    check("final_drain", bus.bit_count < 7'd33, 1'b1);
    check("full_seen", full_seen != 0, 1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
